frame_painter: RTL and testbench
================================

// Module: frame_painter
// PURPOSE
//  Downstream of the colour mux: sweeps the 160x120 frame once per request and drives the VGA adapter.
//  - Each request generates one ROM address per pixel.
//  - Selects the image through memorySel/black.
//  - Absorbs the ROM read latency.
//  - Emits x/y/colour/plot, one pixel per clock.
//  The game FSM issues start (image) or clear (black fill), then waits for done.
// PARAMETERS
//  W        160  frame width in pixels
//  H        120  frame height in pixels
//  ROM_LAT  1    clocks from romAddr change to valid romColor (legal: 1..3)
// PORTS
//  clk        in   1   system clock, rising edge
//  resetn     in   1   asynchronous active-low reset
//  start      in   1   1-clk pulse: paint image imgSel
//  clear      in   1   1-clk pulse: paint whole frame black (priority over start)
//  imgSel     in   7   image index, same encoding as memorySel
//  romColor   in   3   pixel colour returned by colour mux, valid ROM_LAT clks after romAddr
//  romAddr    out  15  y*W + x of pixel being fetched
//  memorySel  out  7   latched imgSel, drives colour mux select
//  black      out  1   latched clear request, forces mux output to 3'b000
//  x          out  8   VGA pixel column
//  y          out  7   VGA pixel row
//  colour     out  3   VGA pixel colour
//  plot       out  1   VGA write enable, one pixel per high clock
//  busy       out  1   high from accepted request until done
//  done       out  1   1-clk pulse after last pixel plotted
// BEHAVIOUR
//  Reset (async, resetn=0): all outputs 0, state IDLE, counters 0.
//  - Reset mid-frame abandons the frame; no done pulse.
//  FSM states: IDLE -> LOAD -> SCAN -> DRAIN -> FIN -> IDLE.
//  IDLE
//   - On clear: latch black=1 and keep memorySel.
//   - Else on start: latch memorySel=imgSel and black=0.
//   - Either request sets busy=1 next clk.
//   - start/clear while busy are ignored; no queuing.
//  LOAD: 1 clk. Scan counters (sx,sy) set to 0; romAddr=0.
//  SCAN
//   - Each clk issues (sx,sy) and romAddr = sy*W+sx, then advances sx.
//   - When sx==W-1: sx wraps to 0 and sy increments.
//   - After issuing (W-1,H-1), go to DRAIN.
//   - romAddr is kept as a running counter (+1 per pixel); no multiplier. It wraps to 0 only via LOAD.
//  Pipeline
//   - (sx,sy,valid) delayed ROM_LAT clks in a shift register.
//   - When delayed valid=1: x,y = delayed coords, colour = romColor (3'b000 if black), plot=1.
//   - First plot occurs ROM_LAT+1 clks after LOAD, for pixel (0,0).
//  DRAIN: hold for ROM_LAT clks until the pipeline empties, then FIN.
//  FIN: done=1 for 1 clk, busy=0 at the same edge, then IDLE.
//  Frame totals
//   - Exactly W*H plot pulses per frame (19200 at defaults).
//   - No gaps and no duplicates; raster order, row-major.
//   - Request-to-done latency = W*H + ROM_LAT + 2 clks.
//  x,y,colour hold their last values when plot=0.
//  - memorySel and black hold until the next accepted request.
//  start and clear in the same clk: clear wins, start dropped.
// STRUCTURE
//  Shared package/header: SCREEN_W=160, SCREEN_H=120, COLOUR_W=3, ADDR_W=15, BLACK=3'b000.
//  Sub-module pixel_scan: sx/sy/addr counters with last-pixel flag.
//  - Inputs: clk, resetn, init, step.
//  - frame_painter adds the FSM, request latch and latency pipe.
// TESTING
//  1 Reset: pulse resetn=0 mid-SCAN -> all outputs 0 immediately; IDLE; no done.
//  2 Full frame: start, imgSel=7'd3, ROM model returns addr[2:0].
//    -> 19200 plots in order.
//    -> Pixel (5,2) gets colour (325 mod 8)=5.
//    -> done exactly 19203 clks after start.
//  3 Clear: clear=1 -> black=1; all 19200 plots colour=000; memorySel unchanged.
//  4 Collision: start+clear same clk -> black frame. start pulsed at pixel 1000 -> ignored.
//  5 Latency: ROM_LAT=2 with a 2-stage ROM model.
//    -> first plot (0,0) 3 clks after LOAD; colours aligned with their pixels.
//    -> done at 19204 clks after start.
//  6 Row wrap: check (159,0) is followed by (0,1); last plot is (159,119); romAddr peaks at 19199.

Source files
------------

// File: rtl/frame_painter_pkg.sv
// Shared constants and types for the frame painter: screen geometry,
// bus widths, the black colour code and the painter FSM state encoding.
package frame_painter_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOUR_W = 3;
    localparam int ADDR_W   = 15;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int SEL_W    = 7;

    localparam logic [COLOUR_W-1:0] BLACK = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SCAN  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } painter_state_e;

endpackage

// File: rtl/frame_painter_if.sv
// Bus between the game FSM / colour mux / VGA adapter and the frame painter.
//
// Request handshake: start and clear are single-clock pulses sampled only
// while busy is low; a pulse seen while busy is high is dropped, never
// queued. clear beats start in the same clock. busy rises the clock after
// an accepted pulse and falls in the same clock that done pulses high.
// Pixel stream: every clock with plot high carries exactly one pixel on
// x/y/colour; there is no back-pressure from the VGA side.
interface frame_painter_if;
    import frame_painter_pkg::*;

    logic                start;
    logic                clear;
    logic [SEL_W-1:0]    imgSel;
    logic [COLOUR_W-1:0] romColor;
    logic [ADDR_W-1:0]   romAddr;
    logic [SEL_W-1:0]    memorySel;
    logic                black;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
    logic                plot;
    logic                busy;
    logic                done;
    painter_state_e      state_dbg;

    // Painter side
    modport slave (
        input  start, clear, imgSel, romColor,
        output romAddr, memorySel, black, x, y, colour, plot, busy, done, state_dbg
    );

    // Requester / ROM / VGA side
    modport master (
        output start, clear, imgSel, romColor,
        input  romAddr, memorySel, black, x, y, colour, plot, busy, done, state_dbg
    );

endinterface

// File: rtl/frame_painter_pixel_scan.sv
// Raster scan counters: column, row and linear ROM address advance together
// one pixel per step. The address is a running counter so no multiplier is
// needed; it only returns to zero through init. Stepping on the last pixel
// holds the counters so the address peaks at W*H-1.
module pixel_scan
    import frame_painter_pkg::*;
#(
    parameter int W = SCREEN_W,
    parameter int H = SCREEN_H
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              init,
    input  logic              step,
    output logic [X_W-1:0]    sx,
    output logic [Y_W-1:0]    sy,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [X_W-1:0] X_LAST = X_W'(W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(H - 1);

    logic [X_W-1:0]    sx_q,   sx_d;
    logic [Y_W-1:0]    sy_q,   sy_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              last_pix;

    assign last_pix = (sx_q == X_LAST) && (sy_q == Y_LAST);

    // Next counter values: clear on init, advance in raster order on step
    always_comb begin
        sx_d   = sx_q;
        sy_d   = sy_q;
        addr_d = addr_q;
        if (init) begin
            sx_d   = '0;
            sy_d   = '0;
            addr_d = '0;
        end else if (step && !last_pix) begin
            addr_d = addr_q + 1'b1;
            if (sx_q == X_LAST) begin
                sx_d = '0;
                sy_d = sy_q + 1'b1;
            end else begin
                sx_d = sx_q + 1'b1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sx_q   <= '0;
            sy_q   <= '0;
            addr_q <= '0;
        end else begin
            sx_q   <= sx_d;
            sy_q   <= sy_d;
            addr_q <= addr_d;
        end
    end

    assign sx   = sx_q;
    assign sy   = sy_q;
    assign addr = addr_q;
    assign last = last_pix;

endmodule

// File: rtl/frame_painter.sv
// Frame painter: on a start/clear request sweeps the whole frame once,
// fetching one ROM colour per pixel and streaming x/y/colour/plot to the
// VGA adapter. Pixel coordinates ride a ROM_LAT-deep shift register so they
// meet their colour when it comes back from the colour mux.
module frame_painter
    import frame_painter_pkg::*;
#(
    parameter int W       = SCREEN_W,
    parameter int H       = SCREEN_H,
    parameter int ROM_LAT = 1
) (
    input logic            clk,
    input logic            resetn,
    frame_painter_if.slave bus
);

    localparam logic [1:0] DRAIN_LAST = 2'(ROM_LAT - 1);

    painter_state_e state_q, state_d;
    logic [1:0]     drain_q, drain_d;

    logic [SEL_W-1:0] mem_sel_q;
    logic             black_q;

    logic              scan_init;
    logic              issue;
    logic [X_W-1:0]    scan_x;
    logic [Y_W-1:0]    scan_y;
    logic [ADDR_W-1:0] scan_addr;
    logic              scan_last;

    logic [X_W-1:0] pipe_x_q [ROM_LAT];
    logic [Y_W-1:0] pipe_y_q [ROM_LAT];
    logic           pipe_v_q [ROM_LAT];

    logic [X_W-1:0]      x_q;
    logic [Y_W-1:0]      y_q;
    logic [COLOUR_W-1:0] colour_q;
    logic                out_valid;
    logic [COLOUR_W-1:0] colour_live;

    pixel_scan #(
        .W (W),
        .H (H)
    ) u_scan (
        .clk    (clk),
        .resetn (resetn),
        .init   (scan_init),
        .step   (issue),
        .sx     (scan_x),
        .sy     (scan_y),
        .addr   (scan_addr),
        .last   (scan_last)
    );

    // FSM state and drain counter registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // FSM next state plus scan control strobes
    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        scan_init = 1'b0;
        issue     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.clear || bus.start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                scan_init = 1'b1;
                state_d   = ST_SCAN;
            end
            ST_SCAN: begin
                issue = 1'b1;
                if (scan_last) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end
            end
            ST_DRAIN: begin
                // Wait for the last issued pixel to leave the latency pipe
                if (drain_q == DRAIN_LAST) state_d = ST_FIN;
                else                       drain_d = drain_q + 1'b1;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request latch: clear wins over start; both ignored unless idle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_sel_q <= '0;
            black_q   <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (bus.clear) begin
                black_q <= 1'b1;
            end else if (bus.start) begin
                mem_sel_q <= bus.imgSel;
                black_q   <= 1'b0;
            end
        end
    end

    // Coordinate/valid shift register matching the ROM read latency
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                pipe_v_q[i] <= 1'b0;
                pipe_x_q[i] <= '0;
                pipe_y_q[i] <= '0;
            end
        end else begin
            pipe_v_q[0] <= issue;
            pipe_x_q[0] <= scan_x;
            pipe_y_q[0] <= scan_y;
            for (int i = 1; i < ROM_LAT; i++) begin
                pipe_v_q[i] <= pipe_v_q[i-1];
                pipe_x_q[i] <= pipe_x_q[i-1];
                pipe_y_q[i] <= pipe_y_q[i-1];
            end
        end
    end

    assign out_valid = pipe_v_q[ROM_LAT-1];

    // Colour for the pixel leaving the pipe; a clear request forces black
    always_comb begin
        colour_live = bus.romColor;
        if (black_q) colour_live = BLACK;
    end

    // Remember the last plotted pixel so x/y/colour hold between plots
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
        end else if (out_valid) begin
            x_q      <= pipe_x_q[ROM_LAT-1];
            y_q      <= pipe_y_q[ROM_LAT-1];
            colour_q <= colour_live;
        end
    end

    assign bus.romAddr   = scan_addr;
    assign bus.memorySel = mem_sel_q;
    assign bus.black     = black_q;
    assign bus.plot      = out_valid;
    assign bus.x         = out_valid ? pipe_x_q[ROM_LAT-1] : x_q;
    assign bus.y         = out_valid ? pipe_y_q[ROM_LAT-1] : y_q;
    assign bus.colour    = out_valid ? colour_live : colour_q;
    assign bus.busy      = (state_q == ST_LOAD) || (state_q == ST_SCAN) || (state_q == ST_DRAIN);
    assign bus.done      = (state_q == ST_FIN);
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_frame_painter.sv
// Directed bench for frame_painter: one instance with a 1-clock ROM and one
// with a 2-clock ROM, both ROM models returning romAddr[2:0].
module tb_frame_painter;
  import frame_painter_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  frame_painter_if if1 ();
  frame_painter_if if2 ();

  frame_painter #(.W(SCREEN_W), .H(SCREEN_H), .ROM_LAT(1)) u_dut1 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (if1.slave)
  );

  frame_painter #(.W(SCREEN_W), .H(SCREEN_H), .ROM_LAT(2)) u_dut2 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (if2.slave)
  );

  // ROM models: colour = low three address bits, 1 and 2 clocks late
  logic [2:0] rom2_s1;
  always @(posedge clk) begin
    if1.romColor <= if1.romAddr[2:0];
    rom2_s1      <= if2.romAddr[2:0];
    if2.romColor <= rom2_s1;
  end

  // Monitored instance select
  logic       mon_sel2;
  logic       mon_plot, mon_done, mon_busy;
  logic [7:0] mon_x;
  logic [6:0] mon_y;
  logic [2:0] mon_colour;
  logic [14:0] mon_addr;
  painter_state_e mon_state;

  always_comb begin
    if (mon_sel2) begin
      mon_plot = if2.plot; mon_done = if2.done; mon_busy = if2.busy;
      mon_x = if2.x; mon_y = if2.y; mon_colour = if2.colour;
      mon_addr = if2.romAddr; mon_state = if2.state_dbg;
    end else begin
      mon_plot = if1.plot; mon_done = if1.done; mon_busy = if1.busy;
      mon_x = if1.x; mon_y = if1.y; mon_colour = if1.colour;
      mon_addr = if1.romAddr; mon_state = if1.state_dbg;
    end
  end

  int checks = 0;
  int failures = 0;

  // Frame monitor state
  int         plot_cnt, order_err, done_cnt, done_cyc, first_plot_cyc, load_cyc, addr_peak, start_cyc;
  int         exp_x, exp_y, exp_addr;
  logic       exp_black, wrap_ok, busy_at_done;
  logic [2:0] px52;
  logic [7:0] last_x;
  logic [6:0] last_y;
  logic [2:0] exp_col;

  // Scoreboard on the falling edge: raster order, colour, timing marks
  always @(negedge clk) begin
    if (mon_state == ST_LOAD) load_cyc = cyc;
    if (int'(mon_addr) > addr_peak) addr_peak = int'(mon_addr);
    if (mon_plot) begin
      exp_col = exp_black ? 3'b000 : exp_addr[2:0];
      if (plot_cnt == 0) first_plot_cyc = cyc;
      else if (last_x == 8'd159 && last_y == 7'd0 && mon_x == 8'd0 && mon_y == 7'd1) wrap_ok = 1'b1;
      if (int'(mon_x) != exp_x || int'(mon_y) != exp_y || mon_colour !== exp_col) order_err++;
      if (mon_x == 8'd5 && mon_y == 7'd2) px52 = mon_colour;
      last_x = mon_x;
      last_y = mon_y;
      plot_cnt++;
      exp_addr++;
      if (exp_x == 159) begin exp_x = 0; exp_y++; end
      else exp_x++;
    end
    if (mon_done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = mon_busy;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic reset_mon(input logic sel2, input logic blk);
    mon_sel2 = sel2; exp_black = blk;
    plot_cnt = 0; order_err = 0; done_cnt = 0; done_cyc = 0;
    first_plot_cyc = 0; load_cyc = 0; addr_peak = 0;
    exp_x = 0; exp_y = 0; exp_addr = 0;
    wrap_ok = 1'b0; busy_at_done = 1'b1; px52 = 3'b111;
    last_x = '0; last_y = '0;
  endtask

  // Drive one request pulse for one clock; called just after a rising edge
  task automatic pulse_req(input logic sel2, input logic s, input logic c, input logic [6:0] img);
    if (sel2) begin if2.start = s; if2.clear = c; if2.imgSel = img; end
    else      begin if1.start = s; if1.clear = c; if1.imgSel = img; end
    start_cyc = cyc;
    @(posedge clk); #1;
    if1.start = 1'b0; if1.clear = 1'b0;
    if2.start = 1'b0; if2.clear = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 25000) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(done_cnt != 0), 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_plots(input int target);
    int n = 0;
    while (plot_cnt < target && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    check("plot_wait", 32'(plot_cnt >= target), 32'd1);
  endtask

  initial begin
    if1.start = 1'b0; if1.clear = 1'b0; if1.imgSel = '0;
    if2.start = 1'b0; if2.clear = 1'b0; if2.imgSel = '0;
    reset_mon(1'b0, 1'b0);

    // Power-on reset
    #1;
    check("por_plot", 32'(if1.plot), 32'd0);
    check("por_busy", 32'(if1.busy), 32'd0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;
    check("rst_state1", 32'(if1.state_dbg), 32'(ST_IDLE));
    check("rst_state2", 32'(if2.state_dbg), 32'(ST_IDLE));
    check("rst_addr", 32'(if1.romAddr), 32'd0);
    check("rst_done", 32'(if1.done), 32'd0);
    check("rst_memsel", 32'(if1.memorySel), 32'd0);
    check("rst_black2", 32'(if2.black), 32'd0);

    // Reset mid-SCAN abandons the frame
    reset_mon(1'b0, 1'b0);
    pulse_req(1'b0, 1'b1, 1'b0, 7'd3);
    wait_plots(50);
    #2 resetn = 1'b0;
    #1;
    check("mid_plot", 32'(if1.plot), 32'd0);
    check("mid_busy", 32'(if1.busy), 32'd0);
    check("mid_addr", 32'(if1.romAddr), 32'd0);
    check("mid_x", 32'(if1.x), 32'd0);
    check("mid_y", 32'(if1.y), 32'd0);
    check("mid_colour", 32'(if1.colour), 32'd0);
    check("mid_memsel", 32'(if1.memorySel), 32'd0);
    check("mid_state", 32'(if1.state_dbg), 32'(ST_IDLE));
    @(posedge clk); #1 resetn = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("mid_no_done", 32'(done_cnt), 32'd0);

    // Full image frame, ROM_LAT=1
    reset_mon(1'b0, 1'b0);
    pulse_req(1'b0, 1'b1, 1'b0, 7'd3);
    check("img_busy", 32'(if1.busy), 32'd1);
    wait_done("img_done_seen");
    check("img_plots", 32'(plot_cnt), 32'd19200);
    check("img_order", 32'(order_err), 32'd0);
    check("img_px52", 32'(px52), 32'd5);
    check("img_latency", 32'(done_cyc - start_cyc), 32'd19203);
    check("img_first", 32'(first_plot_cyc - load_cyc), 32'd2);
    check("img_done_cnt", 32'(done_cnt), 32'd1);
    check("img_busy_at_done", 32'(busy_at_done), 32'd0);
    check("img_wrap", 32'(wrap_ok), 32'd1);
    check("img_last_x", 32'(last_x), 32'd159);
    check("img_last_y", 32'(last_y), 32'd119);
    check("img_addr_peak", 32'(addr_peak), 32'd19199);
    check("img_hold_x", 32'(if1.x), 32'd159);
    check("img_hold_y", 32'(if1.y), 32'd119);
    check("img_memsel", 32'(if1.memorySel), 32'd3);
    check("img_black", 32'(if1.black), 32'd0);
    check("img_idle_busy", 32'(if1.busy), 32'd0);

    // start+clear together: clear wins; a start mid-frame is ignored
    reset_mon(1'b0, 1'b1);
    pulse_req(1'b0, 1'b1, 1'b1, 7'd5);
    check("col_black", 32'(if1.black), 32'd1);
    check("col_memsel", 32'(if1.memorySel), 32'd3);
    check("col_state", 32'(if1.state_dbg), 32'(ST_LOAD));
    wait_plots(1000);
    if1.start = 1'b1; if1.imgSel = 7'd7;
    @(posedge clk); #1;
    if1.start = 1'b0;
    check("ign_busy", 32'(if1.busy), 32'd1);
    check("ign_state", 32'(if1.state_dbg), 32'(ST_SCAN));
    check("ign_memsel", 32'(if1.memorySel), 32'd3);
    check("ign_black", 32'(if1.black), 32'd1);
    wait_done("col_done_seen");
    check("col_plots", 32'(plot_cnt), 32'd19200);
    check("col_order", 32'(order_err), 32'd0);
    check("col_done_cnt", 32'(done_cnt), 32'd1);
    check("col_latency", 32'(done_cyc - start_cyc), 32'd19203);
    check("col_state_idle", 32'(if1.state_dbg), 32'(ST_IDLE));

    // Image frame with ROM_LAT=2
    reset_mon(1'b1, 1'b0);
    pulse_req(1'b1, 1'b1, 1'b0, 7'h41);
    wait_done("lat2_done_seen");
    check("lat2_first", 32'(first_plot_cyc - load_cyc), 32'd3);
    check("lat2_latency", 32'(done_cyc - start_cyc), 32'd19204);
    check("lat2_plots", 32'(plot_cnt), 32'd19200);
    check("lat2_order", 32'(order_err), 32'd0);
    check("lat2_px52", 32'(px52), 32'd5);
    check("lat2_wrap", 32'(wrap_ok), 32'd1);
    check("lat2_last_x", 32'(last_x), 32'd159);
    check("lat2_last_y", 32'(last_y), 32'd119);
    check("lat2_memsel", 32'(if2.memorySel), 32'h41);

    // Clear frame on the ROM_LAT=2 instance
    reset_mon(1'b1, 1'b1);
    pulse_req(1'b1, 1'b0, 1'b1, 7'h22);
    check("clr_black", 32'(if2.black), 32'd1);
    wait_done("clr_done_seen");
    check("clr_plots", 32'(plot_cnt), 32'd19200);
    check("clr_order", 32'(order_err), 32'd0);
    check("clr_memsel", 32'(if2.memorySel), 32'h41);
    check("clr_latency", 32'(done_cyc - start_cyc), 32'd19204);
    check("clr_hold_colour", 32'(if2.colour), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
